// File: rtl/sdrc_bs_convert_pipe_if.sv
// sdrc_bs_convert_pipe_if: transfer-controller and application-port bundle of the SDRAM bus-width converter
interface sdrc_bs_convert_pipe_if #(
    parameter int APP_DW = 32,
    parameter int SDR_DW = 32
) ();
    localparam int APP_BW = APP_DW / 8;
    localparam int SDR_BW = SDR_DW / 8;
    logic [1:0]        sdr_width;
    logic              x2a_wrstart;
    logic              x2a_wrnext;
    logic              x2a_wrlast;
    logic [SDR_DW-1:0] a2x_wrdt;
    logic [SDR_BW-1:0] a2x_wren_n;
    logic [APP_DW-1:0] app_wr_data;
    logic [APP_BW-1:0] app_wr_en_n;
    logic              app_wr_next;
    logic              app_last_wr;
    logic              x2a_rdstart;
    logic              x2a_rdok;
    logic              x2a_rdlast;
    logic [SDR_DW-1:0] x2a_rddt;
    logic [APP_DW-1:0] app_rd_data;
    logic [APP_BW-1:0] app_rd_be;
    logic              app_rd_last;
    logic              app_rd_valid;
    logic              app_rd_ready;
    logic              rd_overflow;
    modport slave (
        input  sdr_width, x2a_wrstart, x2a_wrnext, x2a_wrlast, app_wr_data, app_wr_en_n,
        input  x2a_rdstart, x2a_rdok, x2a_rdlast, x2a_rddt, app_rd_ready,
        output a2x_wrdt, a2x_wren_n, app_wr_next, app_last_wr,
        output app_rd_data, app_rd_be, app_rd_last, app_rd_valid, rd_overflow
    );
    modport master (
        output sdr_width, x2a_wrstart, x2a_wrnext, x2a_wrlast, app_wr_data, app_wr_en_n,
        output x2a_rdstart, x2a_rdok, x2a_rdlast, x2a_rddt, app_rd_ready,
        input  a2x_wrdt, a2x_wren_n, app_wr_next, app_last_wr,
        input  app_rd_data, app_rd_be, app_rd_last, app_rd_valid, rd_overflow
    );
endinterface

// File: rtl/sdrc_bs_convert_pipe.sv
// sdrc_bs_convert_pipe: run-time lane-width converter between application words and SDRAM lanes,
// with partial-word flush, byte-valid mask and a registered read FIFO.
module sdrc_bs_convert_pipe #(
    parameter int APP_DW        = 32,
    parameter int SDR_DW        = 32,
    parameter int RD_FIFO_DEPTH = 4
) (
    input logic clk,
    input logic reset,
    sdrc_bs_convert_pipe_if.slave bus
);
    localparam int APP_BW = APP_DW / 8;
    localparam int SDR_BW = SDR_DW / 8;
    localparam int AW     = $clog2(RD_FIFO_DEPTH);
    localparam int EW     = APP_DW + APP_BW + 1;

    logic [1:0]        lsh;
    logic [2:0]        last_lane;
    logic [31:0]       lmask32;
    logic [3:0]        bmask4;
    logic [2:0]        wr_lane, rd_lane, lane;
    logic [APP_DW-1:0] asm_q, base, word;
    logic [APP_BW-1:0] mask_q, base_m, mask;
    logic              push, pop, full, wr_en;
    logic [EW-1:0]     mem [RD_FIFO_DEPTH];
    logic [EW-1:0]     entry, head_n;
    logic [AW-1:0]     rptr, wptr, rptr_n;
    logic [AW:0]       cnt, cnt_n;
    logic [APP_DW-1:0] rd_data;
    logic [APP_BW-1:0] rd_be;
    logic              rd_last, rd_valid, overflow;

    // lsh is log2 of the lane width in bytes
    always_comb begin
        lsh       = bus.sdr_width[1] ? 2'd0 : bus.sdr_width[0] ? 2'd1 : 2'd2;
        last_lane = 3'((APP_BW >> lsh) - 1);
        lmask32   = 32'hFFFF_FFFF >> (32 - (8 << lsh));
        bmask4    = 4'hF >> (4 - (1 << lsh));
    end

    assign bus.a2x_wrdt    = SDR_DW'(bus.app_wr_data >> (int'(wr_lane) << (lsh + 3))) & lmask32[SDR_DW-1:0];
    assign bus.a2x_wren_n  = SDR_BW'(bus.app_wr_en_n >> (int'(wr_lane) << lsh)) | ~bmask4[SDR_BW-1:0];
    assign bus.app_wr_next = bus.x2a_wrnext & (wr_lane == last_lane | bus.x2a_wrlast);
    assign bus.app_last_wr = bus.x2a_wrlast;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wr_lane <= '0;
        else if (bus.x2a_wrstart | (bus.x2a_wrnext & bus.x2a_wrlast))
            wr_lane <= '0;
        else if (bus.x2a_wrnext)
            wr_lane <= wr_lane == last_lane ? 3'd0 : wr_lane + 3'd1;
    end

    // A start in the same cycle as a beat wins, so the beat lands in lane 0 of an empty word
    always_comb begin
        lane   = bus.x2a_rdstart ? 3'd0 : rd_lane;
        base   = bus.x2a_rdstart ? '0 : asm_q;
        base_m = bus.x2a_rdstart ? '0 : mask_q;
        word   = base | (APP_DW'(bus.x2a_rddt & lmask32[SDR_DW-1:0]) << (int'(lane) << (lsh + 3)));
        mask   = base_m | (APP_BW'(bmask4) << (int'(lane) << lsh));
        push   = bus.x2a_rdok & (lane == last_lane | bus.x2a_rdlast);
        pop    = rd_valid & bus.app_rd_ready;
        full   = cnt == (AW+1)'(RD_FIFO_DEPTH);
        wr_en  = push & (~full | pop);
        entry  = {word, mask, bus.x2a_rdlast};
        rptr_n = rptr + AW'(pop);
        cnt_n  = cnt + (AW+1)'(wr_en) - (AW+1)'(pop);
        head_n = (wr_en && wptr == rptr_n) ? entry : mem[rptr_n];
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr] <= entry;
    end

    // The assembly register is cleared on every push so unwritten bytes of a partial word read as 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_lane  <= '0;
            asm_q    <= '0;
            mask_q   <= '0;
            rptr     <= '0;
            wptr     <= '0;
            cnt      <= '0;
            rd_data  <= '0;
            rd_be    <= '0;
            rd_last  <= 1'b0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (bus.x2a_rdok) begin
                rd_lane <= push ? 3'd0 : lane + 3'd1;
                asm_q   <= push ? '0 : word;
                mask_q  <= push ? '0 : mask;
            end else if (bus.x2a_rdstart) begin
                rd_lane <= '0;
                asm_q   <= '0;
                mask_q  <= '0;
            end
            rptr                       <= rptr_n;
            wptr                       <= wptr + AW'(wr_en);
            cnt                        <= cnt_n;
            {rd_data, rd_be, rd_last}  <= cnt_n != '0 ? head_n : '0;
            rd_valid                   <= cnt_n != '0;
            overflow                   <= overflow | (push & ~wr_en);
        end
    end

    assign bus.app_rd_data  = rd_data;
    assign bus.app_rd_be    = rd_be;
    assign bus.app_rd_last  = rd_last;
    assign bus.app_rd_valid = rd_valid;
    assign bus.rd_overflow  = overflow;
endmodule

// File: tb/tb_sdrc_bs_convert_pipe.sv
// tb_sdrc_bs_convert_pipe: randomized and directed checks of the bus-width converter against
// a queue-based reference model (32/32 instance) plus a directed wide-word check (64/8 instance).
module tb_sdrc_bs_convert_pipe;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  be;
        logic        l;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sdrc_bs_convert_pipe_if #(.APP_DW(32), .SDR_DW(32)) b ();
    sdrc_bs_convert_pipe_if #(.APP_DW(64), .SDR_DW(8))  w ();

    sdrc_bs_convert_pipe #(.APP_DW(32), .SDR_DW(32), .RD_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(b)
    );
    sdrc_bs_convert_pipe #(.APP_DW(64), .SDR_DW(8), .RD_FIFO_DEPTH(DEPTH)) dut64 (
        .clk(clk), .reset(reset), .bus(w)
    );

    ent_t        fifo_q[$];
    logic [31:0] beats_q[$];
    bit          ovf_m = 0;
    logic [31:0] wr_words[16];
    logic [3:0]  wr_ens[16];
    int          wr_i = 0;

    function automatic int lbytes(input logic [1:0] sw);
        return sw[1] ? 1 : sw[0] ? 2 : 4;
    endfunction

    task automatic idle();
        b.x2a_wrstart = 0; b.x2a_wrnext = 0; b.x2a_wrlast = 0;
        b.app_wr_data = '0; b.app_wr_en_n = '1;
        b.x2a_rdstart = 0; b.x2a_rdok = 0; b.x2a_rdlast = 0; b.x2a_rddt = '0; b.app_rd_ready = 0;
        w.x2a_wrstart = 0; w.x2a_wrnext = 0; w.x2a_wrlast = 0;
        w.app_wr_data = '0; w.app_wr_en_n = '1;
        w.x2a_rdstart = 0; w.x2a_rdok = 0; w.x2a_rdlast = 0; w.x2a_rddt = '0; w.app_rd_ready = 0;
    endtask

    // One read-side cycle: drive, let the model absorb the edge, compare at the falling edge
    task automatic rd_step(input bit st, input bit ok, input bit lst, input logic [31:0] dt, input bit rdy);
        int lb, r, sz0;
        bit pop;
        ent_t e;
        logic [63:0] d;
        logic [7:0] be;
        b.x2a_rdstart = st; b.x2a_rdok = ok; b.x2a_rdlast = lst; b.x2a_rddt = dt; b.app_rd_ready = rdy;
        lb = lbytes(b.sdr_width);
        r = 4 / lb;
        sz0 = fifo_q.size();
        pop = sz0 != 0 && rdy;
        @(posedge clk);
        if (pop) void'(fifo_q.pop_front());
        if (st) beats_q.delete();
        if (ok) begin
            beats_q.push_back(dt);
            if (beats_q.size() == r || lst) begin
                d = '0;
                be = '0;
                foreach (beats_q[k]) begin
                    d |= (64'(beats_q[k]) & ((64'd1 << (8 * lb)) - 1)) << (8 * lb * k);
                    be |= 8'(((1 << lb) - 1) << (lb * k));
                end
                e.d = d[31:0];
                e.be = be[3:0];
                e.l = lst;
                if (sz0 < DEPTH || pop) fifo_q.push_back(e);
                else ovf_m = 1;
                beats_q.delete();
            end
        end
        @(negedge clk);
        vectors++;
        if (b.app_rd_valid !== (fifo_q.size() != 0)) begin
            miscompares++;
            $display("FAIL rd_valid got %0b exp %0b", b.app_rd_valid, fifo_q.size() != 0);
        end
        if (fifo_q.size() != 0) begin
            vectors++;
            if ({b.app_rd_data, b.app_rd_be, b.app_rd_last} !== fifo_q[0]) begin
                miscompares++;
                $display("FAIL rd_head got %h/%b/%b exp %h/%b/%b", b.app_rd_data, b.app_rd_be,
                         b.app_rd_last, fifo_q[0].d, fifo_q[0].be, fifo_q[0].l);
            end
        end
        vectors++;
        if (b.rd_overflow !== ovf_m) begin
            miscompares++;
            $display("FAIL rd_overflow got %0b exp %0b", b.rd_overflow, ovf_m);
        end
    endtask

    // One write-side cycle: the model picks the word and lane from the beat index
    task automatic wr_step(input bit st, input bit nx, input bit lst, input bit chk);
        int lb, r, lane, wi;
        logic [31:0] edt;
        logic [3:0] bm, een;
        bit enx;
        lb = lbytes(b.sdr_width);
        r = 4 / lb;
        lane = wr_i % r;
        wi = wr_i / r;
        b.app_wr_data = wr_words[wi]; b.app_wr_en_n = wr_ens[wi];
        b.x2a_wrstart = st; b.x2a_wrnext = nx; b.x2a_wrlast = lst;
        edt = 32'((64'(wr_words[wi]) >> (8 * lb * lane)) & ((64'd1 << (8 * lb)) - 1));
        bm = 4'((1 << lb) - 1);
        een = (4'(wr_ens[wi] >> (lb * lane)) & bm) | ~bm;
        enx = nx && (lane == r - 1 || lst);
        #1;
        if (chk) begin
            vectors += 3;
            if (b.a2x_wrdt !== edt) begin
                miscompares++;
                $display("FAIL wrdt got %h exp %h", b.a2x_wrdt, edt);
            end
            if (b.a2x_wren_n !== een) begin
                miscompares++;
                $display("FAIL wren_n got %b exp %b", b.a2x_wren_n, een);
            end
            if ({b.app_wr_next, b.app_last_wr} !== {enx, lst}) begin
                miscompares++;
                $display("FAIL wr_next/last got %b%b exp %b%b", b.app_wr_next, b.app_last_wr, enx, lst);
            end
        end
        @(posedge clk);
        if (st) wr_i = 0;
        else if (nx) wr_i = lst ? 0 : wr_i + 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1;
        idle();
        b.sdr_width = 2'b10; w.sdr_width = 2'b10;
        b.app_wr_data = 32'h1234_5678;
        repeat (2) @(negedge clk);
        vectors += 2;
        if ({b.app_rd_valid, b.app_rd_data, b.app_rd_be, b.app_rd_last, b.rd_overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_rd got %b %h %b %b %b", b.app_rd_valid, b.app_rd_data, b.app_rd_be,
                     b.app_rd_last, b.rd_overflow);
        end
        if (b.a2x_wrdt !== 32'h0000_0078) begin
            miscompares++;
            $display("FAIL reset_wrdt8 got %h exp 00000078", b.a2x_wrdt);
        end
        reset = 0;
        b.sdr_width = 2'b00;
        @(negedge clk);
        vectors++;
        if (b.a2x_wrdt !== 32'h1234_5678 || b.app_rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset got wrdt %h valid %b exp 12345678 0", b.a2x_wrdt, b.app_rd_valid);
        end
        idle();
    endtask

    task automatic test_write_plan();
        logic [31:0] edt[4] = '{32'hDD, 32'hCC, 32'hBB, 32'hAA};
        logic [3:0]  een[4] = '{4'hF, 4'hE, 4'hF, 4'hE};
        b.sdr_width = 2'b00; b.app_wr_data = 32'h1234_5678; b.app_wr_en_n = 4'h0;
        b.x2a_wrnext = 1; b.x2a_wrlast = 1;
        #1;
        vectors++;
        if ({b.a2x_wrdt, b.a2x_wren_n, b.app_wr_next} !== {32'h1234_5678, 4'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL wr32 got %h %b %b exp 12345678 0000 1", b.a2x_wrdt, b.a2x_wren_n, b.app_wr_next);
        end
        @(negedge clk);
        b.sdr_width = 2'b10; b.app_wr_data = 32'hAABB_CCDD; b.app_wr_en_n = 4'b0101;
        b.x2a_wrnext = 0; b.x2a_wrlast = 0; b.x2a_wrstart = 1;
        @(negedge clk);
        b.x2a_wrstart = 0;
        for (int i = 0; i < 4; i++) begin
            b.x2a_wrnext = 1; b.x2a_wrlast = i == 3;
            #1;
            vectors++;
            if ({b.a2x_wrdt, b.a2x_wren_n, b.app_wr_next} !== {edt[i], een[i], i == 3}) begin
                miscompares++;
                $display("FAIL wr8 beat %0d got %h %b %b exp %h %b %b", i, b.a2x_wrdt, b.a2x_wren_n,
                         b.app_wr_next, edt[i], een[i], i == 3);
            end
            @(negedge clk);
        end
        idle();
        wr_i = 0;
    endtask

    task automatic test_write_random();
        int len;
        bit abort;
        for (int n = 0; n < 25; n++) begin
            b.sdr_width = 2'($urandom % 4);
            len = 1 + $urandom % 10;
            abort = $urandom % 4 == 0;
            for (int k = 0; k < 16; k++) begin
                wr_words[k] = $urandom;
                wr_ens[k] = 4'($urandom);
            end
            wr_step(1, 0, 0, 0);
            for (int i = 0; i < len; i++) begin
                while ($urandom % 3 == 0) wr_step(0, 0, 0, 1);
                wr_step(0, 1, !abort && i == len - 1, 1);
            end
            wr_step(0, 0, 0, 1);
        end
        idle();
    endtask

    task automatic test_read_plan();
        b.sdr_width = 2'b00;
        rd_step(0, 1, 0, 32'hCAFE_F00D, 1);
        vectors++;
        if ({b.app_rd_valid, b.app_rd_data, b.app_rd_be} !== {1'b1, 32'hCAFE_F00D, 4'hF}) begin
            miscompares++;
            $display("FAIL rd32 got %b %h %b exp 1 cafef00d 1111", b.app_rd_valid, b.app_rd_data, b.app_rd_be);
        end
        b.sdr_width = 2'b01;
        rd_step(1, 1, 0, 32'h1111, 1);
        rd_step(0, 1, 0, 32'h2222, 1);
        vectors++;
        if ({b.app_rd_data, b.app_rd_be, b.app_rd_last} !== {32'h2222_1111, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL rd16_w0 got %h %b %b exp 22221111 1111 0", b.app_rd_data, b.app_rd_be, b.app_rd_last);
        end
        rd_step(0, 1, 1, 32'h3333, 1);
        vectors++;
        if ({b.app_rd_data, b.app_rd_be, b.app_rd_last} !== {32'h0000_3333, 4'h3, 1'b1}) begin
            miscompares++;
            $display("FAIL rd16_w1 got %h %b %b exp 00003333 0011 1", b.app_rd_data, b.app_rd_be, b.app_rd_last);
        end
        rd_step(0, 0, 0, 0, 1);
        idle();
    endtask

    task automatic test_overflow();
        b.sdr_width = 2'b00;
        for (int i = 0; i < 5; i++) rd_step(0, 1, 0, 32'h100 + i, 0);
        vectors++;
        if ({b.app_rd_valid, b.rd_overflow} !== 2'b11) begin
            miscompares++;
            $display("FAIL ovf_flags got valid %b ovf %b exp 1 1", b.app_rd_valid, b.rd_overflow);
        end
        for (int j = 0; j < 6; j++) begin
            vectors++;
            if (b.app_rd_valid !== (j < 4) || (j < 4 && b.app_rd_data !== 32'h100 + j)) begin
                miscompares++;
                $display("FAIL ovf_pop %0d got %b %h exp %b %h", j, b.app_rd_valid, b.app_rd_data, j < 4, 32'h100 + j);
            end
            rd_step(0, 0, 0, 0, 1);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        b.sdr_width = 2'b00;
        for (int i = 0; i < 5; i++) rd_step(0, 1, 0, $urandom, 0);
        b.sdr_width = 2'b10;
        rd_step(1, 1, 0, 32'hEE, 0);
        rd_step(0, 1, 0, 32'hFF, 0);
        idle();
        #2 reset = 1;
        #1;
        vectors++;
        if ({b.app_rd_valid, b.app_rd_data, b.app_rd_be, b.app_rd_last, b.rd_overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid got %b %h %b %b %b", b.app_rd_valid, b.app_rd_data, b.app_rd_be,
                     b.app_rd_last, b.rd_overflow);
        end
        fifo_q.delete();
        beats_q.delete();
        ovf_m = 0;
        wr_i = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        rd_step(0, 1, 0, 32'h11, 1);
        rd_step(0, 1, 0, 32'h22, 1);
        rd_step(0, 1, 0, 32'h33, 1);
        rd_step(0, 1, 1, 32'h44, 1);
        vectors++;
        if ({b.app_rd_valid, b.app_rd_data, b.app_rd_be, b.app_rd_last} !== {1'b1, 32'h4433_2211, 4'hF, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_after got %b %h %b %b exp 1 44332211 1111 1", b.app_rd_valid, b.app_rd_data,
                     b.app_rd_be, b.app_rd_last);
        end
        rd_step(0, 0, 0, 0, 1);
        idle();
    endtask

    task automatic test_back_to_back();
        bit st, rdy;
        for (int c = 0; c < 300; c++) begin
            st = c == 0 || $urandom % 12 == 0;
            if (st) b.sdr_width = 2'($urandom % 4);
            rdy = c < 200 ? $urandom % 4 != 0 : $urandom % 4 == 0;
            rd_step(st, $urandom % 4 != 0, $urandom % 5 == 0, $urandom, rdy);
        end
        repeat (6) rd_step(0, 0, 0, 0, 1);
        idle();
    endtask

    task automatic test_wide();
        w.sdr_width = 2'b10;
        w.app_rd_ready = 1;
        w.x2a_rdstart = 1;
        @(negedge clk);
        w.x2a_rdstart = 0;
        for (int i = 0; i < 8; i++) begin
            w.x2a_rdok = 1; w.x2a_rddt = 8'(i + 1); w.x2a_rdlast = i == 7;
            @(negedge clk);
        end
        w.x2a_rdok = 0; w.x2a_rdlast = 0;
        vectors++;
        if ({w.app_rd_valid, w.app_rd_data, w.app_rd_be, w.app_rd_last} !== {1'b1, 64'h0807_0605_0403_0201, 8'hFF, 1'b1}) begin
            miscompares++;
            $display("FAIL wide_full got %b %h %b %b exp 1 0807060504030201 ff 1", w.app_rd_valid,
                     w.app_rd_data, w.app_rd_be, w.app_rd_last);
        end
        for (int i = 0; i < 3; i++) begin
            w.x2a_rdok = 1; w.x2a_rddt = 8'hAA + 8'(i * 17); w.x2a_rdlast = i == 2;
            @(negedge clk);
        end
        w.x2a_rdok = 0; w.x2a_rdlast = 0;
        vectors++;
        if ({w.app_rd_valid, w.app_rd_data, w.app_rd_be, w.app_rd_last} !== {1'b1, 64'h0000_0000_00CC_BBAA, 8'h07, 1'b1}) begin
            miscompares++;
            $display("FAIL wide_part got %b %h %b %b exp 1 0000000000ccbbaa 07 1", w.app_rd_valid,
                     w.app_rd_data, w.app_rd_be, w.app_rd_last);
        end
        @(negedge clk);
        vectors++;
        if (w.app_rd_valid !== 1'b0 || w.rd_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL wide_drain got valid %b ovf %b exp 0 0", w.app_rd_valid, w.rd_overflow);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_plan();
        test_write_random();
        test_read_plan();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
